// File: rtl/gradient_accum_memory_pkg.sv
// Shared types and default widths for the gradient accumulation memory.
//   state_t : CLEAR sweeps the array to zero after reset, RUN serves traffic
//   op_t    : kind of operation held in the capture stage
package gradient_accum_memory_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_GRAD_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 24;
  localparam int unsigned DEF_DEPTH_BITS = 10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage

// File: rtl/gradient_accum_memory_ram.sv
// Simple dual-port accumulator array: one synchronous read and one write per cycle.
// A read and write to the same index on one edge returns the old contents.
//   clock   : rising-edge clock
//   wr_en   : write strobe
//   wr_idx  : write index
//   wr_data : write data
//   rd_idx  : read index, sampled every cycle
//   rd_data : registered read data
module gradient_accum_memory_ram #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH_BITS = 10
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_idx,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_BITS-1:0] rd_idx,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // Nonblocking read of the pre-write contents gives read-old-data on collision.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/gradient_accum_memory.sv
// Memory-side responder for the gradient write stream. Each accepted write is
// read-modify-write accumulated into the array with signed saturation; a
// readback port returns accumulated words. The array is cleared after reset.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   mem_address/value     : gradient write request, valid/ready handshake
//   mem_valid, mem_ready  : mem_ready is low in CLEAR and whenever rd_req is high
//   rd_req, rd_address    : readback request (single-cycle pulse)
//   rd_valid, rd_data     : readback response, one cycle after rd_req
//   init_done             : array clear finished
//   write_count           : applied writes (wraps)
//   drop_count, sat_count : dropped out-of-range writes / saturated sums (hold at max)
module gradient_accum_memory
  import gradient_accum_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned GRAD_WIDTH = DEF_GRAD_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned DEPTH_BITS = DEF_DEPTH_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [GRAD_WIDTH-1:0] mem_value,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  rd_valid,
  output logic [ACC_WIDTH-1:0]  rd_data,
  output logic                  init_done,
  output logic [31:0]           write_count,
  output logic [15:0]           drop_count,
  output logic [15:0]           sat_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned EXT   = ACC_WIDTH + 1 - GRAD_WIDTH;

  // Returns {sat_flag, clamped}: sum at ACC_WIDTH+1 bits, clamped to the signed range.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0]  acc,
                                                 input logic [GRAD_WIDTH-1:0] grad);
    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] result;
    sum = {acc[ACC_WIDTH-1], acc} + {{EXT{grad[GRAD_WIDTH-1]}}, grad};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      // Top bit is the true sign of the overflowed sum.
      if (sum[ACC_WIDTH]) begin
        result = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        result = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      result = {1'b0, sum[ACC_WIDTH-1:0]};
    end
    return result;
  endfunction

  state_t                state;
  state_t                state_next;
  logic [DEPTH_BITS-1:0] clr_idx;

  // Capture-stage registers; while c_valid is set for a write this is stage W.
  logic                  c_valid;
  op_t                   c_op;
  logic [DEPTH_BITS-1:0] c_idx;
  logic [GRAD_WIDTH-1:0] c_value;
  logic                  c_in_range;
  logic                  c_fwd;
  logic [ACC_WIDTH-1:0]  c_fwd_data;

  logic                  wr_accept;
  logic                  rd_accept;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DEPTH_BITS-1:0] op_idx;
  logic                  op_in_range;
  logic                  w_write;
  logic                  fwd_hit;
  logic [ACC_WIDTH-1:0]  ram_rdata;
  logic [ACC_WIDTH-1:0]  cap_data;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_sat;
  logic                  ram_wr_en;
  logic [DEPTH_BITS-1:0] ram_wr_idx;
  logic [ACC_WIDTH-1:0]  ram_wr_data;

  // Next-state and handshake; a readback request blocks the write port that cycle.
  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    case (state)
      CLEAR: begin
        if (clr_idx == DEPTH_BITS'(DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        mem_ready = !rd_req;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign wr_accept   = mem_valid && mem_ready;
  assign rd_accept   = (state == RUN) && rd_req;
  assign wr_in_range = (mem_address[ADDR_WIDTH-1:DEPTH_BITS] == '0);
  assign rd_in_range = (rd_address[ADDR_WIDTH-1:DEPTH_BITS] == '0);
  assign op_idx      = rd_accept ? rd_address[DEPTH_BITS-1:0] : mem_address[DEPTH_BITS-1:0];
  assign op_in_range = rd_accept ? rd_in_range : wr_in_range;

  assign w_write  = c_valid && (c_op == OP_WR) && c_in_range;
  assign cap_data = c_fwd ? c_fwd_data : ram_rdata;
  assign {w_sat, w_sum} = sat_add(cap_data, c_value);

  // The array still holds the old word when W writes the same index this edge.
  assign fwd_hit = w_write && (c_idx == op_idx);

  // CLEAR and stage W share the write port; reset discards any in-flight write.
  assign ram_wr_en   = !reset && ((state == CLEAR) || w_write);
  assign ram_wr_idx  = (state == CLEAR) ? clr_idx : c_idx;
  assign ram_wr_data = (state == CLEAR) ? '0 : w_sum;

  assign rd_data = (rd_valid && c_in_range) ? cap_data : '0;

  gradient_accum_memory_ram #(
    .WIDTH      (ACC_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_wr_en),
    .wr_idx  (ram_wr_idx),
    .wr_data (ram_wr_data),
    .rd_idx  (op_idx),
    .rd_data (ram_rdata)
  );

  // State, capture pipeline and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      init_done   <= 1'b0;
      c_valid     <= 1'b0;
      c_op        <= OP_WR;
      c_idx       <= '0;
      c_value     <= '0;
      c_in_range  <= 1'b0;
      c_fwd       <= 1'b0;
      c_fwd_data  <= '0;
      rd_valid    <= 1'b0;
      write_count <= '0;
      drop_count  <= '0;
      sat_count   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + DEPTH_BITS'(1);
      end
      if (state_next == RUN) begin
        init_done <= 1'b1;
      end
      c_valid    <= wr_accept || rd_accept;
      c_op       <= rd_accept ? OP_RD : OP_WR;
      c_idx      <= op_idx;
      c_value    <= mem_value;
      c_in_range <= op_in_range;
      c_fwd      <= fwd_hit;
      c_fwd_data <= w_sum;
      rd_valid   <= rd_accept;
      if (wr_accept && !wr_in_range && (drop_count != '1)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (w_write) begin
        write_count <= write_count + 32'd1;
        if (w_sat && (sat_count != '1)) begin
          sat_count <= sat_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gradient_accum_memory.sv
// Directed bench for gradient_accum_memory with hand-computed expected values.
module tb_gradient_accum_memory;

  logic        clock;
  logic        reset;
  logic [31:0] mem_address;
  logic [15:0] mem_value;
  logic        mem_valid;
  logic        mem_ready;
  logic        rd_req;
  logic [31:0] rd_address;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        init_done;
  logic [31:0] write_count;
  logic [15:0] drop_count;
  logic [15:0] sat_count;

  int passed = 0;
  int total  = 0;

  gradient_accum_memory dut (
    .clock       (clock),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_value   (mem_value),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .rd_req      (rd_req),
    .rd_address  (rd_address),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .init_done   (init_done),
    .write_count (write_count),
    .drop_count  (drop_count),
    .sat_count   (sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [15:0] val);
    mem_valid   = 1'b1;
    mem_address = addr;
    mem_value   = val;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [23:0] exp);
    rd_req     = 1'b1;
    rd_address = addr;
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  // Counts edges after reset release until init_done, bounded; flags early mem_ready.
  task automatic wait_init(input string tag);
    int   n;
    logic early_ready;
    n = 0;
    early_ready = 1'b0;
    while (!init_done && n < 2000) begin
      if (mem_ready) early_ready = 1'b1;
      tick();
      n++;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd1024);
    check({tag, "_ready_in_clear"}, 32'(early_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    mem_valid   = 1'b0;
    mem_address = '0;
    mem_value   = '0;
    rd_req      = 1'b0;
    rd_address  = '0;

    // Reset state
    tick(); tick(); tick();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_write_count", write_count, 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    reset = 1'b0;
    wait_init("init");
    check("run_ready", 32'(mem_ready), 32'd1);
    read_check("clr_rd0", 32'h0, 24'h0);
    read_check("clr_rd7", 32'h7, 24'h0);
    read_check("clr_rd3ff", 32'h3FF, 24'h0);

    // +5 then -3 back to back, read right after (forwarding path)
    do_write(32'h7, 16'd5);
    do_write(32'h7, 16'hFFFD);
    read_check("acc7", 32'h7, 24'd2);
    check("acc7_write_count", write_count, 32'd2);

    // Positive saturation: 256*32767 = 8388352 fits, remaining 44 clamp
    for (int i = 0; i < 300; i++) begin
      do_write(32'h1, 16'd32767);
    end
    read_check("sat1", 32'h1, 24'h7FFFFF);
    check("sat_count", 32'(sat_count), 32'd44);
    check("sat_write_count", write_count, 32'd302);

    // Out-of-range write is accepted but dropped
    mem_valid   = 1'b1;
    mem_address = 32'h400;
    mem_value   = 16'd100;
    #1;
    check("oor_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    check("oor_drop_count", 32'(drop_count), 32'd1);
    read_check("oor_rd0", 32'h0, 24'h0);
    read_check("oor_rd400", 32'h400, 24'h0);
    check("oor_write_count", write_count, 32'd302);

    // Streaming writes with a readback pulse in the middle
    mem_address = 32'h10;
    mem_value   = 16'd1;
    mem_valid   = 1'b1;
    tick();
    tick();
    rd_req     = 1'b1;
    rd_address = 32'h10;
    #1;
    check("stream_ready_at_t", 32'(mem_ready), 32'd0);
    tick();
    check("stream_rd_valid", 32'(rd_valid), 32'd1);
    check("stream_rd_data", 32'(rd_data), 32'd2);
    rd_req = 1'b0;
    #1;
    check("stream_ready_after", 32'(mem_ready), 32'd1);
    tick();
    tick();
    mem_valid = 1'b0;
    tick();
    check("stream_rd_valid_low", 32'(rd_valid), 32'd0);
    read_check("stream_total", 32'h10, 24'd4);
    check("stream_write_count", write_count, 32'd306);

    // Reset while a write sits in stage W
    do_write(32'h5, 16'd9);
    reset = 1'b1;
    tick();
    check("mid_write_count", write_count, 32'd0);
    check("mid_drop_count", 32'(drop_count), 32'd0);
    check("mid_sat_count", 32'(sat_count), 32'd0);
    check("mid_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    wait_init("reinit");
    read_check("reinit_rd5", 32'h5, 24'h0);
    read_check("reinit_rd1", 32'h1, 24'h0);
    read_check("reinit_rd7", 32'h7, 24'h0);
    read_check("reinit_rd10", 32'h10, 24'h0);
    check("reinit_write_count", write_count, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
